// File: rtl/ksa_pkg.sv
// Shared types for the S-memory arbiter slice.
// Address/data widths and requester identities of the KSA cores.
package ksa_pkg;

  localparam int S_ADDR_W = 8;
  localparam int S_DATA_W = 8;

  typedef enum logic [1:0] {
    REQ_INIT,
    REQ_SHUFFLE,
    REQ_DECRYPT
  } req_id_t;

  typedef logic [S_ADDR_W-1:0] s_addr_t;
  typedef logic [S_DATA_W-1:0] s_data_t;

endpackage

// File: rtl/s_mem_arbiter_rr_pick.sv
// Cyclic priority encoder: first requester after last wins.
// Pure combinational; returns zero when nobody requests.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  win_o
);

  logic found;

  always_comb begin
    win_o = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req_i[(int'(last_i) + k) % N]) begin
        win_o[(int'(last_i) + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/s_mem_arbiter.sv
// Round-robin owner of the single-port S-memory with lockable
// grants and a tag pipe routing read data back to its issuer.
module s_mem_arbiter
  import ksa_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int ADDR_W   = S_ADDR_W,
  parameter int DATA_W   = S_DATA_W,
  parameter int READ_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ-1:0]        req_wren,
  input  logic [N_REQ-1:0]        req_rden,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        rd_valid,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_data,
  output logic                    mem_wren,
  output logic                    mem_rden,
  output logic                    busy
);

  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0] grant_q, grant_d, pick;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    own_idx, win_idx;
  logic             hold, act;

  logic [READ_LAT-1:0]         tag_v_q;
  logic [READ_LAT-1:0][IW-1:0] tag_id_q;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req_i  (req),
    .last_i (last_q),
    .win_o  (pick)
  );

  always_comb begin
    own_idx = '0;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) own_idx = IW'(i);
      if (grant_d[i]) win_idx = IW'(i);
    end
  end

  // A locked owner keeps the RAM only while it still requests.
  always_comb begin
    hold    = |(grant_q & lock & req);
    grant_d = hold ? grant_q : pick;
    last_d  = last_q;
    if (|grant_d && grant_d != grant_q) last_d = win_idx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q <= '0;
      last_q  <= IW'(N_REQ - 1);
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // A write wins over a simultaneous read request.
  always_comb begin
    ack      = grant_q & req;
    act      = |ack;
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    mem_rden = 1'b0;
    if (act) begin
      mem_addr = req_addr[own_idx*ADDR_W +: ADDR_W];
      mem_data = req_data[own_idx*DATA_W +: DATA_W];
      mem_wren = req_wren[own_idx];
      mem_rden = req_rden[own_idx] & ~req_wren[own_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v_q  <= '0;
      tag_id_q <= '0;
    end else begin
      tag_v_q[0]  <= mem_rden;
      tag_id_q[0] <= own_idx;
      for (int s = 1; s < READ_LAT; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end
    end
  end

  always_comb begin
    rd_valid = '0;
    if (tag_v_q[READ_LAT-1]) rd_valid[tag_id_q[READ_LAT-1]] = 1'b1;
  end

  assign grant = grant_q;
  assign busy  = (|grant_q) | (|tag_v_q);

endmodule
